// File: rtl/group_sched_pkg.sv
// Shared types and sizing helpers for the group row scheduler.
// Holds the FSM state encoding and counter-width arithmetic.
package group_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        RWAIT,
        PADW,
        ROW,
        GAPW,
        DONE
    } sched_st_t;

    localparam int LEN_DEF    = 3;
    localparam int FLUSH_ROWS = LEN_DEF - 1;

    // Bits needed to hold 0..n-1; never less than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/group_row_sched.sv
// Frame/row scheduler feeding the 3-row line-buffer group: vsync, then per row
// hsync, a pad wait and SIZE*CHANNEL beats, followed by LEN-1 zero flush rows.
module group_row_sched
    import group_sched_pkg::*;
#(
    parameter int WIDTH_D = 27,
    parameter int SIZE    = 28,
    parameter int CHANNEL = 128,
    parameter int LEN     = FLUSH_ROWS + 1,
    parameter int GAP     = 0,
    parameter int PADWAIT = 21,
    parameter int VS_LEN  = 4
) (
    input  logic               i_sclk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_row_avail,
    input  logic               i_tvalid,
    input  logic [WIDTH_D-1:0] i_tdata,
    output logic               o_rd,
    output logic               o_vsync,
    output logic               o_hsync,
    output logic               o_valid,
    output logic [WIDTH_D-1:0] o_tdata,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    localparam int BEATS = SIZE * CHANNEL;
    localparam int ROWS  = SIZE + LEN - 1;
    localparam int BW    = cnt_w(BEATS);
    localparam int RW    = cnt_w(ROWS + 1);
    localparam int WW    = cnt_w(max3(VS_LEN, PADWAIT, GAP));

    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [RW-1:0] ROW_FLUSH = RW'(SIZE);
    localparam logic [WW-1:0] VS_LAST   = WW'(VS_LEN - 1);
    localparam logic [WW-1:0] PAD_LAST  = WW'(PADWAIT - 1);
    localparam logic [WW-1:0] GAP_LAST  = WW'(GAP - 1);

    sched_st_t          state, state_nxt;
    logic [WW-1:0]      wait_cnt;
    logic [BW-1:0]      beat_cnt;
    logic [RW-1:0]      row_cnt;
    logic               image_row, beat_last;
    logic               vsync_d, hsync_d, valid_d, busy_d, done_d, err_d;
    logic [WIDTH_D-1:0] tdata_d;

    assign image_row = (row_cnt < ROW_FLUSH);
    assign beat_last = (beat_cnt == BEAT_LAST);
    assign o_rd      = (state == ROW) && image_row;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (i_start) state_nxt = VSYNC;
            VSYNC: if (wait_cnt == VS_LAST) state_nxt = RWAIT;
            RWAIT: if (i_row_avail || !image_row) state_nxt = (PADWAIT > 0) ? PADW : ROW;
            PADW:  if (wait_cnt == PAD_LAST) state_nxt = ROW;
            ROW: begin
                if (beat_last) begin
                    if (row_cnt == ROW_LAST) state_nxt = DONE;
                    else                     state_nxt = (GAP > 0) ? GAPW : RWAIT;
                end
            end
            GAPW:  if (wait_cnt == GAP_LAST) state_nxt = RWAIT;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The wait counter is shared by VSYNC, PADW and GAPW and restarts on every state change.
    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wait_cnt <= '0;
            beat_cnt <= '0;
            row_cnt  <= '0;
        end else begin
            if (state_nxt != state || !(state inside {VSYNC, PADW, GAPW})) wait_cnt <= '0;
            else                                                            wait_cnt <= wait_cnt + 1'b1;

            if (state == IDLE && state_nxt == VSYNC) begin
                beat_cnt <= '0;
                row_cnt  <= '0;
            end else if (state == ROW) begin
                beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
                if (beat_last) row_cnt <= row_cnt + 1'b1;
            end
        end
    end

    // Underrun beats still go out (as zero) so downstream row timing never moves.
    always_comb begin
        vsync_d = (state_nxt == VSYNC);
        busy_d  = (state_nxt != IDLE);
        hsync_d = (state == RWAIT) && (state_nxt != RWAIT);
        valid_d = (state == ROW);
        done_d  = (state == DONE);
        tdata_d = '0;
        if (state == ROW && image_row && i_tvalid) tdata_d = i_tdata;
        err_d = o_err;
        if (state == IDLE && i_start)                     err_d = 1'b0;
        else if (state == ROW && image_row && !i_tvalid)  err_d = 1'b1;
    end

    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_vsync <= 1'b0;
            o_hsync <= 1'b0;
            o_valid <= 1'b0;
            o_tdata <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            o_vsync <= vsync_d;
            o_hsync <= hsync_d;
            o_valid <= valid_d;
            o_tdata <= tdata_d;
            o_busy  <= busy_d;
            o_done  <= done_d;
            o_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_group_row_sched.sv
// Scoreboard bench for group_row_sched: stimulus pushes the expected framing
// events, a monitor pops and compares them whenever an output strobe appears.
module tb_group_row_sched;
    import group_sched_pkg::*;

    localparam int WD    = 27;
    localparam int SZ    = 4;
    localparam int CH    = 2;
    localparam int LN    = FLUSH_ROWS + 1;
    localparam int GP    = 2;
    localparam int PW    = 3;
    localparam int VS    = 4;
    localparam int BEATS = SZ * CH;
    localparam int NROWS = SZ + LN - 1;

    typedef struct packed {
        logic [3:0]  unit;
        logic [3:0]  kind;
        logic [15:0] cyc;
        logic [31:0] data;
    } evt_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, start6 = 1'b0;
    logic          row_avail = 1'b1, tvalid = 1'b1;
    logic [WD-1:0] tdata;
    logic          o_rd, o_vsync, o_hsync, o_valid, o_busy, o_done, o_err;
    logic [WD-1:0] o_tdata;
    logic          o_rd6, o_vsync6, o_hsync6, o_valid6, o_busy6, o_done6, o_err6;
    logic [WD-1:0] o_tdata6;

    evt_t          exp_q[$];
    int            n_total = 0, n_bad = 0;
    int            cyc = 0, start_cyc = 0;
    logic [WD-1:0] up_data, exp_data;

    group_row_sched #(.WIDTH_D(WD), .SIZE(SZ), .CHANNEL(CH), .LEN(LN), .GAP(GP),
                      .PADWAIT(PW), .VS_LEN(VS)) dut (
        .i_sclk(clk), .i_rst_n(rst_n), .i_start(start), .i_row_avail(row_avail),
        .i_tvalid(tvalid), .i_tdata(tdata), .o_rd(o_rd), .o_vsync(o_vsync),
        .o_hsync(o_hsync), .o_valid(o_valid), .o_tdata(o_tdata), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err)
    );

    group_row_sched #(.WIDTH_D(WD), .SIZE(SZ), .CHANNEL(CH), .LEN(LN), .GAP(0),
                      .PADWAIT(0), .VS_LEN(VS)) dut6 (
        .i_sclk(clk), .i_rst_n(rst_n), .i_start(start6), .i_row_avail(row_avail),
        .i_tvalid(tvalid), .i_tdata(tdata), .o_rd(o_rd6), .o_vsync(o_vsync6),
        .o_hsync(o_hsync6), .o_valid(o_valid6), .o_tdata(o_tdata6), .o_busy(o_busy6),
        .o_done(o_done6), .o_err(o_err6)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int unit, input int kind, input int c, input logic [31:0] d,
                           input int cutoff);
        evt_t e;
        e.unit = 4'(unit);
        e.kind = 4'(kind);
        e.cyc  = 16'(c);
        e.data = d;
        if (c <= cutoff) exp_q.push_back(e);
    endtask

    // Expected frame timeline; cycle 1 is the first cycle after the edge that accepts start.
    task automatic push_frame(input int unit, input int pw, input int gap, input int stall_row,
                              input int stall_cyc, input int ur_row, input int ur_beat,
                              input int cutoff);
        int t;
        for (int i = 1; i <= VS; i++) push_ev(unit, 0, i, 32'd0, cutoff);
        t = VS + 1;
        for (int r = 0; r < NROWS; r++) begin
            if (r == stall_row) t += stall_cyc;
            push_ev(unit, 1, t + 1, 32'd0, cutoff);
            for (int j = 0; j < BEATS; j++) begin
                int          c;
                logic [31:0] d;
                c = t + 2 + pw + j;
                d = 32'd0;
                if (r < SZ && !(r == ur_row && j == ur_beat) && c <= cutoff) begin
                    d = 32'(exp_data);
                    exp_data++;
                end
                push_ev(unit, 2, c, d, cutoff);
            end
            t += 1 + pw + BEATS;
            if (r != NROWS - 1) t += gap;
        end
        push_ev(unit, 3, t + 1, 32'd0, cutoff);
    endtask

    // FWFT upstream: the head word advances after each cycle with o_rd and i_tvalid high.
    initial begin
        logic pop;
        up_data = 27'h100;
        tdata   = up_data;
        forever begin
            @(negedge clk);
            #2;
            pop = (o_rd | o_rd6) && tvalid;
            @(posedge clk);
            #1;
            if (pop) begin
                up_data++;
                tdata = up_data;
            end
        end
    end

    initial forever begin
        int            rel;
        logic [3:0]    flags;
        logic [WD-1:0] d;
        evt_t          act;
        @(negedge clk);
        rel = cyc - start_cyc + 1;
        for (int u = 0; u < 2; u++) begin
            flags = (u == 0) ? {o_done, o_valid, o_hsync, o_vsync}
                             : {o_done6, o_valid6, o_hsync6, o_vsync6};
            d     = (u == 0) ? o_tdata : o_tdata6;
            for (int k = 0; k < 4; k++) begin
                if (flags[k]) begin
                    act.unit = 4'(u);
                    act.kind = 4'(k);
                    act.cyc  = 16'(rel);
                    act.data = (k == 2) ? 32'(d) : 32'd0;
                    if (exp_q.size() == 0) begin
                        n_total++;
                        n_bad++;
                        $display("FAIL unexpected_event: got 0x%0h, want none", act);
                    end else begin
                        check("event", 64'(act), 64'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic start_frame(input int unit);
        if (unit == 0) start = 1'b1;
        else            start6 = 1'b1;
        start_cyc = cyc + 1;
        @(negedge clk);
        start  = 1'b0;
        start6 = 1'b0;
    endtask

    task automatic wait_rel(input int n);
        int guard;
        guard = 0;
        while ((cyc - start_cyc + 1) < n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic drain(input string name, input int budget);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < budget) begin
            @(negedge clk);
            g++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_data = 27'h100;
        repeat (3) @(negedge clk);
        check("rst_sync", 64'({o_vsync, o_hsync, o_valid, o_done}), 64'd0);
        check("rst_busy_err", 64'({o_busy, o_err, o_rd}), 64'd0);
        check("rst_tdata", 64'(o_tdata), 64'd0);
        check("rst_outs6", 64'({o_vsync6, o_hsync6, o_valid6, o_busy6, o_done6, o_err6, o_rd6}), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // T1: plain frame
        push_frame(0, PW, GP, -1, 0, -1, -1, 100000);
        start_frame(0);
        check("t1_busy_rise", 64'(o_busy), 64'd1);
        wait_rel(8);
        check("t1_rd_padw", 64'(o_rd), 64'd0);
        wait_rel(9);
        check("t1_rd_image", 64'(o_rd), 64'd1);
        wait_rel(65);
        check("t1_rd_flush", 64'(o_rd), 64'd0);
        drain("t1_drain", 200);
        check("t1_busy_fall", 64'(o_busy), 64'd0);

        // T2: row 2 held off for 10 cycles in RWAIT
        push_frame(0, PW, GP, 2, 10, -1, -1, 100000);
        start_frame(0);
        wait_rel(33);
        row_avail = 1'b0;
        wait_rel(43);
        row_avail = 1'b1;
        drain("t2_drain", 200);

        // T3: one-cycle underrun on row 1 beat 3
        push_frame(0, PW, GP, -1, 0, 1, 3, 100000);
        start_frame(0);
        check("t3_err_before", 64'(o_err), 64'd0);
        wait_rel(26);
        tvalid = 1'b0;
        wait_rel(27);
        tvalid = 1'b1;
        wait_rel(28);
        check("t3_err_set", 64'(o_err), 64'd1);
        drain("t3_drain", 200);
        check("t3_err_sticky", 64'(o_err), 64'd1);

        // T4: start pulse during ROW is ignored; new start clears err
        push_frame(0, PW, GP, -1, 0, -1, -1, 100000);
        start_frame(0);
        check("t4_err_clear", 64'(o_err), 64'd0);
        wait_rel(30);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t4_busy", 64'(o_busy), 64'd1);
        drain("t4_drain", 200);
        check("t4_idle_busy", 64'(o_busy), 64'd0);

        // T5: reset during PADW of row 3, then a clean frame
        push_frame(0, PW, GP, -1, 0, -1, -1, 49);
        start_frame(0);
        wait_rel(49);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_sync", 64'({o_vsync, o_hsync, o_valid, o_done}), 64'd0);
        check("t5_rst_busy", 64'({o_busy, o_err, o_rd}), 64'd0);
        check("t5_rst_tdata", 64'(o_tdata), 64'd0);
        check("t5_queue", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        push_frame(0, PW, GP, -1, 0, -1, -1, 100000);
        start_frame(0);
        drain("t5_drain", 200);

        // T6: PADWAIT=0, GAP=0 instance
        push_frame(1, 0, 0, -1, 0, -1, -1, 100000);
        start_frame(1);
        check("t6_busy_rise", 64'(o_busy6), 64'd1);
        drain("t6_drain", 200);
        check("t6_busy_fall", 64'(o_busy6), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
